// File: rtl/mult_sequencer_pkg.sv
// Shared widths, FSM encoding and product payload for the shift-add multiplier.
package mult_sequencer_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned PROD_W = 2 * WIDTH;

  // 2'b11 is unused; the sequencer recovers from it to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
  } product_t;

  function automatic logic is_last_iter(input logic [CNT_W-1:0] cnt);
    return cnt == CNT_W'(WIDTH - 1);
  endfunction

endpackage

// File: rtl/adder_subtractor.sv
// Shared WIDTH-bit adder/subtractor: ctl0 selects A-B, ctl1 adds a carry-in; 00 is a plain add.
module adder_subtractor
  import mult_sequencer_pkg::*;
(
  input  logic             ctl0_i,
  input  logic             ctl1_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  logic [WIDTH-1:0] b_eff;
  logic             cin;

  assign b_eff = ctl0_i ? ~b_i : b_i;
  assign cin   = ctl0_i | ctl1_i;

  assign {cout_o, sum_o} = (WIDTH + 1)'(a_i) + (WIDTH + 1)'(b_eff) + (WIDTH + 1)'(cin);

endmodule

// File: rtl/mult_sequencer_step.sv
// One shift-add iteration: gate the multiplicand by q[0], add to acc, shift {cout,sum,q} right.
module mult_sequencer_step
  import mult_sequencer_pkg::*;
(
  input  logic [WIDTH-1:0] m_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] q_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] sum;
  logic             cout;

  assign b_sel = q_i[0] ? m_i : '0;

  adder_subtractor u_addsub (
    .ctl0_i (1'b0),
    .ctl1_i (1'b0),
    .a_i    (acc_i),
    .b_i    (b_sel),
    .sum_o  (sum),
    .cout_o (cout)
  );

  assign acc_o = {cout, sum[WIDTH-1:1]};
  assign q_o   = {sum[0], q_i[WIDTH-1:1]};

endmodule

// File: rtl/mult_sequencer.sv
// 32x32 unsigned iterative multiplier controller with valid/ready operand and result handshakes.
// Optional MULT_ZERO_SKIP_EN: a zero operand goes straight from IDLE to DONE with product 0.
module mult_sequencer
  import mult_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [PROD_W-1:0] product
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] step_acc, step_q;
  product_t         prod;

  mult_sequencer_step u_step (
    .m_i   (m_q),
    .acc_i (acc_q),
    .q_i   (q_q),
    .acc_o (step_acc),
    .q_o   (step_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and state-decoded handshake outputs; no input reaches an output combinationally.
  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    acc_d       = acc_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    start_ready = 1'b0;
    busy        = 1'b0;
    res_valid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          m_d     = a;
          q_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
`ifdef MULT_ZERO_SKIP_EN
          if ((a == '0) || (b == '0)) begin
            q_d     = '0;
            state_d = ST_DONE;
          end
`endif
        end
      end
      ST_RUN: begin
        busy  = 1'b1;
        acc_d = step_acc;
        q_d   = step_q;
        cnt_d = cnt_q + CNT_W'(1);
        // The counter wraps to 0 on the last iteration, leaving it clean for the next op.
        if (is_last_iter(cnt_q)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign prod.hi = acc_q;
  assign prod.lo = q_q;
  assign product = prod;

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: directed cases plus random operands against a product model.
module tb_mult_sequencer;

`ifdef MULT_ZERO_SKIP_EN
  localparam bit ZERO_SKIP = 1'b1;
`else
  localparam bit ZERO_SKIP = 1'b0;
`endif
  localparam int RUN_LAT = 33;
  localparam int TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] product;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mult_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .product     (product)
  );

  // Full operation: offer (av,bv), check busy/latency/product, optionally stall the result, then handshake.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input int hold,
                        input bit toggle, input string tag);
    logic [63:0] exp_prod;
    int          exp_lat;
    bit          exp_busy;
    int          cyc;
    exp_prod = 64'(av) * 64'(bv);
    exp_lat  = (ZERO_SKIP && (av == 32'd0 || bv == 32'd0)) ? 1 : RUN_LAT;
    exp_busy = (exp_lat == RUN_LAT);

    @(negedge clk);
    a = av; b = bv; start_valid = 1'b1; res_ready = (hold == 0);
    n_cmp++;
    if (start_ready !== 1'b1) begin
      n_err++; $display("FAIL %s start_ready before accept: got %b want 1", tag, start_ready);
    end
    @(negedge clk);
    start_valid = 1'b0;
    cyc = 1;
    while (res_valid !== 1'b1 && cyc < TIMEOUT) begin
      n_cmp++;
      if (busy !== exp_busy || start_ready !== 1'b0) begin
        n_err++; $display("FAIL %s busy/start_ready at cycle %0d: got %b/%b want %b/0",
                          tag, cyc, busy, start_ready, exp_busy);
      end
      if (toggle) start_valid = 1'($urandom);
      a = $urandom; b = $urandom;
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (cyc !== exp_lat) begin
      n_err++; $display("FAIL %s latency: got %0d want %0d", tag, cyc, exp_lat);
    end
    n_cmp++;
    if (product !== exp_prod || busy !== 1'b0) begin
      n_err++; $display("FAIL %s product/busy: got %h/%b want %h/0", tag, product, busy, exp_prod);
    end
    for (int i = 0; i < hold; i++) begin
      if (toggle) start_valid = 1'($urandom);
      a = $urandom; b = $urandom;
      @(negedge clk);
      n_cmp++;
      if (res_valid !== 1'b1 || start_ready !== 1'b0 || product !== exp_prod) begin
        n_err++; $display("FAIL %s stall %0d: valid=%b ready=%b prod=%h want 1/0/%h",
                          tag, i, res_valid, start_ready, product, exp_prod);
      end
    end
    res_ready = 1'b1;
    if (toggle) start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    res_ready   = 1'($urandom);
    n_cmp++;
    if (res_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0 || product !== exp_prod) begin
      n_err++; $display("FAIL %s after handshake: valid=%b ready=%b busy=%b prod=%h want 0/1/0/%h",
                        tag, res_valid, start_ready, busy, product, exp_prod);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start_valid = 1'b1; res_ready = 1'b0; a = $urandom; b = $urandom;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || product !== 64'h0) begin
      n_err++; $display("FAIL reset state: ready=%b busy=%b valid=%b prod=%h want 1/0/0/0",
                        start_ready, busy, res_valid, product);
    end
    reset = 1'b0; start_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (start_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset release: ready=%b busy=%b want 1/0", start_ready, busy);
    end
  endtask

  task automatic test_basic();
    run_op(32'd3, 32'd5, 0, 1'b0, "basic_3x5");
  endtask

  task automatic test_carry();
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, "carry_max");
    run_op(32'h8000_0000, 32'd2, 0, 1'b0, "carry_msb");
  endtask

  task automatic test_stall();
    run_op(32'd7, 32'd9, 10, 1'b1, "stall_7x9");
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    @(negedge clk);
    a = 32'd100; b = 32'd200; start_valid = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || product !== 64'h0) begin
      n_err++; $display("FAIL midrun reset: ready=%b busy=%b valid=%b prod=%h want 1/0/0/0",
                        start_ready, busy, res_valid, product);
    end
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1 || busy === 1'b1) cyc++;
    end
    n_cmp++;
    if (cyc !== 0) begin
      n_err++; $display("FAIL midrun abort: valid/busy high for %0d cycles want 0", cyc);
    end
    run_op(32'd100, 32'd200, 0, 1'b0, "midrun_retry");
  endtask

  task automatic test_zero();
    run_op(32'd0, 32'd7, 0, 1'b0, "zero_a");
    run_op(32'h1234_5678, 32'd0, 2, 1'b0, "zero_b");
  endtask

  task automatic test_random();
    logic [31:0] av, bv;
    for (int i = 0; i < 8; i++) begin
      av = $urandom; bv = $urandom;
      if ($urandom_range(0, 3) == 0) av = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) bv = 32'($urandom_range(0, 15));
      run_op(av, bv, $urandom_range(0, 4), 1'($urandom), "random");
    end
  endtask

  task automatic test_back_to_back();
    run_op(32'hDEAD_BEEF, 32'hCAFE_F00D, 0, 1'b0, "b2b_0");
    run_op(32'h0001_0001, 32'hFFFF_0000, 0, 1'b1, "b2b_1");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_stall();
    test_reset_mid_run();
    test_zero();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
- Iterative 32x32 unsigned shift-add multiplier controller. It time-multiplexes one AdderSubtractor instance, driven with ctl0=0 and ctl1=0 (ADD mode), over 32 cycles to produce a 64-bit product.
- It sits beside the ALU as a multi-cycle functional unit.
- Operand acceptance and result delivery each use a valid/ready handshake.

Parameters:
- WIDTH, 32, operand width; fixed to the AdderSubtractor width; other values unsupported.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == WIDTH.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start_valid  input  1  operand pair offered.
- start_ready  output  1  high only in IDLE.
- a  input  32  multiplicand; sampled on accept.
- b  input  32  multiplier; sampled on accept.
- busy  output  1  high in RUN.
- res_valid  output  1  high only in DONE.
- res_ready  input  1  consumer takes result.
- product  output  64  {acc, q}; stable while res_valid=1.

Behaviour:
- Registers:
  - state: IDLE/RUN/DONE.
  - m[31:0]: multiplicand.
  - acc[31:0]: accumulator (upper half).
  - q[31:0]: multiplier, shifting into the low product half.
  - cnt[CNT_W-1:0]: iteration counter.
- Reset (async, any state):
  - state=IDLE; m, acc, q, cnt = 0.
  - Outputs: start_ready=1, busy=0, res_valid=0, product=0.
- IDLE:
  - start_ready=1.
  - Accept on start_valid & start_ready: m<=a, q<=b, acc<=0, cnt<=0, state<=RUN.
- RUN (one iteration per cycle):
  - Adder inputs: A=acc, B=(q[0] ? m : 0). Adder output is sum[31:0], carry c=Cout.
  - When q[0]=0, B=0, so c=0 and sum=acc.
  - Update: acc<={c, sum[31:1]}; q<={sum[0], q[31:1]}; cnt<=cnt+1.
  - When cnt==31 at the edge, state<=DONE.
  - Adder Zero/Overflow outputs are ignored.
- DONE:
  - res_valid=1; product={acc,q} held.
  - On res_valid & res_ready, state<=IDLE. product keeps its value until the next accept.
- Latency: accept edge = cycle 0; RUN cycles 1..32; res_valid high from cycle 33.
- Throughput: one operation per 34 cycles minimum, with res_ready held high.
- Boundary rules:
  - start_valid during RUN/DONE: ignored, no queueing (start_ready=0).
  - res_ready while res_valid=0: no effect.
  - res_valid=1 with res_ready=0: hold indefinitely; product, a and b changes have no effect.
  - Handshake completion and a new start_valid in the same cycle: the new op is not accepted until the following IDLE cycle.
  - cnt wraps 31->0 on the final iteration; no separate compare for 32.
  - Reset mid-RUN: abort without output; the next accepted op computes correctly.
- Combinational outputs are decoded from state only, with no input-to-output paths: start_ready=(state==IDLE), busy=(state==RUN), res_valid=(state==DONE).

Optional Feature:
- Macro: MULT_ZERO_SKIP_EN.
- Defined: on accept, if a==0 or b==0, load acc=0, q=0 and go IDLE->DONE directly. res_valid rises at cycle 1 with product=0; RUN is never entered (busy stays 0).
- Undefined: every op takes the full 32 RUN cycles regardless of operand values.

Decomposition:
- Shared header mult_constants.v (`define) holds:
  - MULT_WIDTH 32 and MULT_ITER 32.
  - State encodings: MULT_IDLE 2'b00, MULT_RUN 2'b01, MULT_DONE 2'b10; 2'b11 illegal, recovers to IDLE.
- One natural sub-module, mult_step: combinational B-select gating plus the shift/concat logic around the AdderSubtractor instance.
- mult_sequencer holds the FSM, counter and registers.

Test Plan:
- Reset while start_valid=1 -> start_ready=1, busy=0, res_valid=0, product=64'h0; no accept until reset deasserts.
- a=3, b=5, res_ready=1 -> res_valid high at cycle 33, product=64'h0000_0000_0000_000F; start_ready=1 the next cycle.
- a=32'hFFFF_FFFF, b=32'hFFFF_FFFF (exercises Cout) -> product=64'hFFFF_FFFE_0000_0001; also a=32'h8000_0000, b=2 -> 64'h0000_0001_0000_0000.
- a=7, b=9 with res_ready=0 for 10 cycles after res_valid, and start_valid toggling throughout -> product stays 64'h3F, start_ready=0; exactly one handshake when res_ready rises.
- reset pulse at RUN cycle 10 of a=100, b=200 -> immediate IDLE, res_valid never rises; next op a=100, b=200 -> product=20000.
- a=0, b=7 -> with MULT_ZERO_SKIP_EN, res_valid at cycle 1 and busy never high; without it, res_valid at cycle 33; product=0 in both builds.
